lut_phase_scheduler: RTL and testbench

- Time-multiplexes one shared sine LUT (single address port, registered read, fixed latency) across three phase channels.
- Each channel has a fixed phase offset; a common phase accumulator advances by a programmable step once per sample round.
- Each round captures the three LUT reads and commits them to the outputs on the same edge, so the three phases are always coherent.
- Sits between the sample-rate tick source and the PWM/lattice modulators; owns all LUT addressing.

---
 rtl/lut_phase_scheduler.sv | 177 +++++++++++++++++
 tb/tb_lut_phase_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lut_phase_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lut_phase_scheduler: shares one registered sine LUT across three phase
// channels and commits the three samples coherently once per round.
// Rev 1.0
// ----------------------------------------------------------------------------
module lut_phase_scheduler #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int N_SAMPLES = 20000,
  parameter int OFF2      = 6667,
  parameter int OFF3      = 13333,
  parameter int LUT_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic [ADDR_W-1:0] step,
  input  logic              load,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_ISSUE2 = 3'd3,
    S_DRAIN  = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] N_MAX    = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] OFF2_C   = ADDR_W'(OFF2);
  localparam logic [ADDR_W-1:0] OFF3_C   = ADDR_W'(OFF3);
  localparam logic [2:0]        TAG_NONE = 3'b000;

  // Operands are always below N_SAMPLES, so one conditional subtract suffices.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_EXT) s = s - N_EXT;
    return s[ADDR_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic              overrun_q, overrun_d;
  logic [2:0]        tag_q [LUT_LAT];
  logic [2:0]        tag_d [LUT_LAT];
  logic [2:0]        tag_in;
  logic [2:0]        tag_out;

  assign tag_out = tag_q[LUT_LAT-1];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;
    tag_in    = TAG_NONE;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    out3_d    = out3_q;

    // Tag bit 2 marks a live request, bits 1:0 carry the channel index.
    if (tag_out[2]) begin
      case (tag_out[1:0])
        2'd0:    sh0_d = lut_data;
        2'd1:    sh1_d = lut_data;
        default: sh2_d = lut_data;
      endcase
    end

    if (sample_tick && state_q != S_IDLE) overrun_d = 1'b1;

    // lut_addr is registered, so each address is loaded on entry to its ISSUE state.
    case (state_q)
      S_IDLE: begin
        if (load) begin
          phase_d   = '0;
          overrun_d = 1'b0;
        end else if (sample_tick) begin
          step_d  = (step > N_MAX) ? N_MAX : step;
          addr_d  = phase_q;
          state_d = S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        tag_in  = 3'b100;
        addr_d  = mod_add(phase_q, OFF2_C);
        state_d = S_ISSUE1;
      end
      S_ISSUE1: begin
        tag_in  = 3'b101;
        addr_d  = mod_add(phase_q, OFF3_C);
        state_d = S_ISSUE2;
      end
      S_ISSUE2: begin
        tag_in  = 3'b110;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_out == 3'b110) begin
          out1_d  = sh0_d;
          out2_d  = sh1_d;
          out3_d  = sh2_d;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        phase_d = mod_add(phase_q, step_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tag_d[0] = tag_in;
    for (int i = 1; i < LUT_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      out3_q    <= '0;
      for (int i = 0; i < LUT_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      out3_q    <= out3_d;
      for (int i = 0; i < LUT_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign lut_addr = addr_q;
  assign out1     = out1_q;
  assign out2     = out2_q;
  assign out3     = out3_q;
  assign valid    = (state_q == S_COMMIT);
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_phase_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lut_phase_scheduler: directed vectors against two builds (LUT_LAT 1 and 3)
// driven in lockstep; LUT model returns addr[7:0] after LUT_LAT cycles.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lut_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [14:0] step;
  logic        load;

  logic [14:0] addr1, addr3;
  logic [7:0]  data1, data3;
  logic [7:0]  o1_1, o2_1, o3_1, o1_3, o2_3, o3_3;
  logic        valid1, valid3, busy1, busy3, ov1, ov3;

  logic [7:0]  l1_0, l3_0, l3_1, l3_2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    l1_0 <= addr1[7:0];
    l3_0 <= addr3[7:0];
    l3_1 <= l3_0;
    l3_2 <= l3_1;
  end
  assign data1 = l1_0;
  assign data3 = l3_2;

  lut_phase_scheduler #(.LUT_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .step(step), .load(load),
    .lut_addr(addr1), .lut_data(data1), .out1(o1_1), .out2(o2_1), .out3(o3_1),
    .valid(valid1), .busy(busy1), .overrun(ov1)
  );

  lut_phase_scheduler #(.LUT_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .step(step), .load(load),
    .lut_addr(addr3), .lut_data(data3), .out1(o1_3), .out2(o2_3), .out3(o3_3),
    .valid(valid3), .busy(busy3), .overrun(ov3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy1"}, 32'(busy1), 0);
    chk({tag, " busy3"}, 32'(busy3), 0);
    chk({tag, " valid1"}, 32'(valid1), 0);
    chk({tag, " valid3"}, 32'(valid3), 0);
    chk({tag, " ov1"}, 32'(ov1), 0);
    chk({tag, " ov3"}, 32'(ov3), 0);
    chk({tag, " addr1"}, 32'(addr1), 0);
    chk({tag, " addr3"}, 32'(addr3), 0);
    chk({tag, " outs1"}, {8'd0, o1_1, o2_1, o3_1}, 0);
    chk({tag, " outs3"}, {8'd0, o1_3, o2_3, o3_3}, 0);
  endtask

  task automatic do_load(input string tag, input logic with_tick);
    @(negedge clk);
    load        = 1'b1;
    sample_tick = with_tick;
    @(negedge clk);
    load        = 1'b0;
    sample_tick = 1'b0;
    chk({tag, " busy1"}, 32'(busy1), 0);
    chk({tag, " busy3"}, 32'(busy3), 0);
    chk({tag, " ov1"}, 32'(ov1), 0);
    chk({tag, " ov3"}, 32'(ov3), 0);
  endtask

  // One round; k counts cycles after the tick edge T (cycle T+k).
  task automatic round(input string tag, input logic [14:0] st,
                       input logic [14:0] a0, input logic [14:0] a1, input logic [14:0] a2,
                       input logic extra, input logic abort, input logic exp_ov);
    logic [14:0] ea;
    logic [31:0] eo;
    int          kmax;
    eo   = {8'd0, a0[7:0], a1[7:0], a2[7:0]};
    kmax = abort ? 2 : 10;
    @(negedge clk);
    sample_tick = 1'b1;
    step        = st;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      if (k > 1) @(negedge clk);
      sample_tick = 1'b0;
      ea = (k == 1) ? a0 : (k == 2) ? a1 : a2;
      if (k <= 4) begin
        chk($sformatf("%s addr1 k%0d", tag, k), 32'(addr1), 32'(ea));
        chk($sformatf("%s addr3 k%0d", tag, k), 32'(addr3), 32'(ea));
      end
      chk($sformatf("%s busy1 k%0d", tag, k), 32'(busy1), 32'(k <= 5));
      chk($sformatf("%s busy3 k%0d", tag, k), 32'(busy3), 32'(k <= 7));
      chk($sformatf("%s valid1 k%0d", tag, k), 32'(valid1), 32'(k == 5));
      chk($sformatf("%s valid3 k%0d", tag, k), 32'(valid3), 32'(k == 7));
      if (k == 5) chk({tag, " outs1"}, {8'd0, o1_1, o2_1, o3_1}, eo);
      if (k == 7) chk({tag, " outs3"}, {8'd0, o1_3, o2_3, o3_3}, eo);
      if (extra && k == 3) sample_tick = 1'b1;
    end
    if (abort) begin
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero({tag, " midrst"});
      rst_n = 1'b1;
    end else begin
      chk({tag, " ov1"}, 32'(ov1), 32'(exp_ov));
      chk({tag, " ov3"}, 32'(ov3), 32'(exp_ov));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    step        = '0;
    load        = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    do_load("load0", 1'b0);
    round("basic", 15'd1, 15'd0, 15'd6667, 15'd13333, 1'b0, 1'b0, 1'b0);
    do_load("load1", 1'b0);
    round("clamp", 15'd25000, 15'd0, 15'd6667, 15'd13333, 1'b0, 1'b0, 1'b0);
    round("top", 15'd1, 15'd19999, 15'd6666, 15'd13332, 1'b0, 1'b0, 1'b0);
    round("wrap", 15'd19950, 15'd0, 15'd6667, 15'd13333, 1'b0, 1'b0, 1'b0);
    round("p19950", 15'd100, 15'd19950, 15'd6617, 15'd13283, 1'b0, 1'b0, 1'b0);
    round("p50", 15'd0, 15'd50, 15'd6717, 15'd13383, 1'b0, 1'b0, 1'b0);
    round("abort", 15'd0, 15'd50, 15'd6717, 15'd13383, 1'b0, 1'b1, 1'b0);
    round("postrst", 15'd0, 15'd0, 15'd6667, 15'd13333, 1'b0, 1'b0, 1'b0);
    round("ovr", 15'd1, 15'd0, 15'd6667, 15'd13333, 1'b1, 1'b0, 1'b1);
    round("ovr2", 15'd0, 15'd1, 15'd6668, 15'd13334, 1'b0, 1'b0, 1'b1);
    do_load("loadtick", 1'b1);
    round("afterld", 15'd0, 15'd0, 15'd6667, 15'd13333, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
